// File: rtl/dvi_timing_ctrl.sv
// DVI video timing controller: h/v counters, sync, data-enable and a same-cycle pixel pull.
// Optional colour-bar generator enabled by the DVI_TIMING_PATTERN_EN macro.
module dvi_timing_ctrl #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        I_rgb_clk,
  input  logic        I_rst,
  input  logic        I_enable,
`ifdef DVI_TIMING_PATTERN_EN
  input  logic        I_pattern_sel,
`endif
  input  logic        I_pix_valid,
  input  logic [7:0]  I_pix_r,
  input  logic [7:0]  I_pix_g,
  input  logic [7:0]  I_pix_b,
  output logic        O_pix_req,
  output logic [11:0] O_x,
  output logic [11:0] O_y,
  output logic        O_frame_start,
  output logic        O_rgb_vs,
  output logic        O_rgb_hs,
  output logic        O_rgb_de,
  output logic [7:0]  O_rgb_r,
  output logic [7:0]  O_rgb_g,
  output logic [7:0]  O_rgb_b,
  output logic        O_busy,
  output logic [15:0] O_underflow_cnt
);

  // state    | meaning
  // ST_IDLE  | counters parked at 0, outputs blank
  // ST_RUN   | timing running, pixels pulled
  // ST_DRAIN | enable dropped, finishing the current frame

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] h_q, h_d, v_q, v_d;
  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic [15:0] uf_q, uf_d;
  logic        busy, frame_last, run_active, pix_req, pat_on;

`ifdef DVI_TIMING_PATTERN_EN
  localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
  logic        pat_q, pat_d;
  logic [11:0] bar_px_q, bar_px_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  assign pat_on = pat_q;
`else
  assign pat_on = 1'b0;
`endif

  always_comb begin
    busy       = (state_q != ST_IDLE);
    frame_last = (h_q == H_LAST) && (v_q == V_LAST);
    run_active = busy && (h_q < H_ACT) && (v_q < V_ACT);
    // The source is never asked for a pixel while reset is held, even mid-frame.
    pix_req    = run_active && !pat_on && !I_rst;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (I_enable) state_d = ST_RUN;
      ST_RUN:   if (!I_enable) state_d = frame_last ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (I_enable)        state_d = ST_RUN;
        else if (frame_last) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase

    h_d = h_q;
    v_d = v_q;
    if (!busy) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 12'd1;
    end else begin
      h_d = h_q + 12'd1;
    end

    de_d = run_active;
    hs_d = (busy && (h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
    vs_d = (busy && (v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
    fs_d = run_active && (h_q == '0) && (v_q == '0);

    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (pix_req && I_pix_valid) begin
      r_d = I_pix_r;
      g_d = I_pix_g;
      b_d = I_pix_b;
    end

    uf_d = uf_q;
    if (pix_req && !I_pix_valid && (uf_q != 16'hFFFF)) uf_d = uf_q + 16'd1;

`ifdef DVI_TIMING_PATTERN_EN
    if (run_active && pat_q) begin
      r_d = {8{bar_idx_q[2]}};
      g_d = {8{bar_idx_q[1]}};
      b_d = {8{bar_idx_q[0]}};
    end

    // Latched on the cycle that leads into h=0,v=0 so it holds for the whole frame.
    pat_d = (!busy || frame_last) ? I_pattern_sel : pat_q;

    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (h_d == '0) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (bar_px_q == BAR_LAST) begin
      bar_px_d  = '0;
      bar_idx_d = bar_idx_q + 3'd1;
    end else begin
      bar_px_d  = bar_px_q + 12'd1;
    end
`endif
  end

  always_ff @(posedge I_rgb_clk) begin
    if (I_rst) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      v_q       <= '0;
      de_q      <= 1'b0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      fs_q      <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      uf_q      <= '0;
`ifdef DVI_TIMING_PATTERN_EN
      pat_q     <= 1'b0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      fs_q      <= fs_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      uf_q      <= uf_d;
`ifdef DVI_TIMING_PATTERN_EN
      pat_q     <= pat_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
`endif
    end
  end

  assign O_pix_req       = pix_req;
  assign O_x             = h_q;
  assign O_y             = v_q;
  assign O_frame_start   = fs_q;
  assign O_rgb_de        = de_q;
  assign O_rgb_hs        = hs_q;
  assign O_rgb_vs        = vs_q;
  assign O_rgb_r         = r_q;
  assign O_rgb_g         = g_q;
  assign O_rgb_b         = b_q;
  assign O_busy          = busy;
  assign O_underflow_cnt = uf_q;

endmodule

// File: doc/dvi_timing_ctrl.md
# dvi_timing_ctrl

Video timing controller that sequences the DVI transmitter. It generates the horizontal and vertical counters, sync pulses and data-enable for one video mode, and pulls pixels from an upstream source through a request/valid handshake. Its registered `O_rgb_*` outputs drive the TMDS encoder/serializer inputs directly. It sits in the `I_rgb_clk` domain, between the frame source and the DVI transmitter.

## Interface
- `H_ACTIVE`, 1280, active pixels per line; must be a multiple of 8
- `H_FP`, 110, horizontal front porch, in pixels
- `H_SYNC`, 40, HS pulse width, in pixels
- `H_BP`, 220, horizontal back porch, in pixels
- `V_ACTIVE`, 720, active lines per frame
- `V_FP`, 5, vertical front porch, in lines
- `V_SYNC`, 5, VS pulse width, in lines
- `V_BP`, 20, vertical back porch, in lines
- `HS_POL`, 1, HS active level
- `VS_POL`, 1, VS active level

Ports:
- `I_rgb_clk`  in  1  pixel clock; the only clock
- `I_rst`  in  1  reset; synchronous, active-high
- `I_enable`  in  1  run request
- `I_pix_valid`  in  1  source has the pixel for the current request
- `I_pix_r`, `I_pix_g`, `I_pix_b`  in  8 each  source pixel
- `O_pix_req`  out  1  pixel requested this cycle; combinational from the counters
- `O_x`, `O_y`  out  12 each  coordinates of the pixel being requested; combinational
- `O_frame_start`  out  1  one-cycle pulse, aligned with the first output pixel of a frame
- `O_rgb_vs`, `O_rgb_hs`, `O_rgb_de`  out  1 each  registered timing to the transmitter
- `O_rgb_r`, `O_rgb_g`, `O_rgb_b`  out  8 each  registered pixel to the transmitter
- `O_busy`  out  1  state is not IDLE
- `O_underflow_cnt`  out  16  saturating count of missed pixels

## Operation
Derived totals:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP
- V_TOTAL similarly, from the V_* parameters

Counters:
- `h_cnt` runs 0..H_TOTAL-1 and wraps to 0.
- `v_cnt` increments when `h_cnt` wraps, runs 0..V_TOTAL-1, and wraps to 0.
- Active region: h < H_ACTIVE and v < V_ACTIVE.
- HS is asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
- VS is asserted for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC.

State machine (IDLE, RUN, DRAIN):
- **IDLE:** counters held at 0; `O_pix_req`=0; outputs are blank.
- **IDLE→RUN:** on `I_enable`=1. The first RUN cycle has h=0, v=0.
- **RUN→DRAIN:** on `I_enable`=0.
- **DRAIN:** timing continues unchanged.
  - DRAIN→IDLE after the cycle where h=H_TOTAL-1 and v=V_TOTAL-1, so the frame always completes.
  - DRAIN→RUN if `I_enable` reasserts; timing is not disturbed.

Handshake:
- `O_pix_req` = active region and state ≠ IDLE.
- The source must present data in the same cycle as the request; there is no stall.
- If `O_pix_req` && !`I_pix_valid`:
  - output pixel is 0,0,0;
  - `O_underflow_cnt` increments, saturating at 16'hFFFF.
- `O_underflow_cnt` is cleared only by reset.

## Timing
Latency and alignment:
- Latency is 1 cycle: `O_rgb_*` at cycle N+1 reflect counters and handshake at cycle N.
- `O_frame_start` is registered. It is high in the cycle where `O_rgb_de` first rises for h=0, v=0.

Blanking:
- Outside the active region, `O_rgb_r`/`O_rgb_g`/`O_rgb_b` = 0 and `O_rgb_de` = 0.
- In IDLE, HS and VS sit at their inactive levels.

Reset:
- Reset values: state IDLE; counters 0; `O_rgb_de`=0; `O_rgb_hs`=~HS_POL; `O_rgb_vs`=~VS_POL; RGB=0; `O_frame_start`=0; `O_busy`=0; `O_underflow_cnt`=0.
- `O_pix_req`=0 during reset.
- Reset mid-frame aborts the frame immediately, with no drain.

Other boundary rules:
- `I_enable` toggling inside a frame never shortens or restarts that frame.
- `O_x` = h and `O_y` = v, zero-extended to 12 bits. They are meaningful only while `O_pix_req`=1.

## Configuration
`DVI_TIMING_PATTERN_EN`:
- **When defined:**
  - Adds input `I_pattern_sel` (1 bit).
  - While `I_pattern_sel`=1, `O_pix_req` is forced to 0, the underflow counter is frozen, and active pixels are 8 vertical color bars.
  - Each bar is H_ACTIVE/8 pixels wide. The bar index i (0..7) comes from a bar-width counter, with no divider.
  - Bar colour: r=i[2]?FF:00, g=i[1]?FF:00, b=i[0]?FF:00.
  - `I_pattern_sel` is sampled at frame start only.
- **When undefined:** the port and all pattern logic are absent.

## Test plan
Bench parameters: H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL 12); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL 6); 72-cycle frame.

- **Reset, then RUN:** `I_enable`=1, `I_pix_valid` always 1, RGB = x → first frame_start 1 cycle after enable; DE high for 8 cycles per line with RGB 0..7; HS high at h=9,10; VS high for all 12 cycles of v=4.
- **Period check:** run continuously → frame_start pulses exactly every 72 cycles; 24 DE cycles per frame.
- **Underflow:** drop `I_pix_valid` for pixel (3,1) only → output at that slot is 0,0,0; `O_underflow_cnt`=1; other pixels unaffected.
- **Drain:** deassert `I_enable` at v=1, h=2 → frame finishes; IDLE entered after cycle (11,5); `O_busy` falls; no further DE. Re-enable during DRAIN → no gap in timing.
- **Reset mid-frame:** assert `I_rst` at v=2 → next cycle DE=0, HS=VS=inactive, counter=0, state IDLE.
- **Pattern (`DVI_TIMING_PATTERN_EN` defined, `I_pattern_sel`=1):** each line outputs bars i=0..7, one pixel each: 000000, 0000FF, 00FF00, …, FFFFFF; `O_pix_req`=0; underflow count unchanged.
